// File: rtl/dbi_slave_pkg.sv
// dbi_slave_pkg: shared definitions for the DBI slave register file.
//   - dbi_state_e    : FSM state encoding (IDLE/WAIT/ACK/HOLD)
//   - DBI_WR_PROT_BIT: bit of the protection register that opens RO writes
//   - DBI_OOW_RDATA  : data returned for reads outside the register window
package dbi_slave_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_HOLD = 2'd3
    } dbi_state_e;

    localparam int          DBI_WR_PROT_BIT = 0;
    localparam logic [31:0] DBI_OOW_RDATA   = 32'h0000_0000;

endpackage

// File: rtl/dbi_slave_regbank.sv
// dbi_slave_regbank: NUM_REGS x 32-bit register array.
//   clk, rst_n        : clock, async active-low reset (index 0 -> RST_WORD0, rest 0)
//   wr_en/wr_be       : write strobe and per-byte enables
//   wr_idx/wr_data    : write index and data
//   rd_en/rd_zero     : load rd_data; rd_zero returns the out-of-window constant
//   rd_idx            : read index
//   rd_data           : registered read data, holds until the next rd_en
//   prot_open         : protection-open bit of register PROT_IDX
module dbi_slave_regbank
    import dbi_slave_pkg::*;
#(
    parameter int          NUM_REGS  = 64,
    parameter int          IDX_W     = $clog2(NUM_REGS),
    parameter logic [31:0] RST_WORD0 = 32'h0,
    parameter int          PROT_IDX  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [3:0]       wr_be,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic             rd_en,
    input  logic             rd_zero,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data,
    output logic             prot_open
);

    logic [NUM_REGS-1:0][31:0] regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs    <= '0;
            regs[0] <= RST_WORD0;
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                for (int k = 0; k < 4; k++) begin
                    if (wr_be[k]) regs[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
            if (rd_en) rd_data <= rd_zero ? DBI_OOW_RDATA : regs[rd_idx];
        end
    end

    assign prot_open = regs[PROT_IDX][DBI_WR_PROT_BIT];

endmodule

// File: rtl/dbi_slave_regfile.sv
// dbi_slave_regfile: DBI bus responder backed by a word-addressed register window.
//   clk, rst_n                : clock, async active-low reset
//   drp_dbi_cs                : request, held until ack
//   drp_dbi_cs2_exp           : shadow-bank select (only with DBI_CS2_SHADOW_EN)
//   drp_dbi_wr                : byte write enables, 0 = read
//   drp_dbi_addr/drp_dbi_din  : byte address / write data
//   drp_app_dbi_ro_wr_disable : forces RO registers read-only
//   drp_lbc_dbi_dout          : read data, holds until the next read completes
//   drp_lbc_dbi_ack           : one-cycle completion pulse
// Build option: define DBI_CS2_SHADOW_EN to add a second, unprotected bank
// selected by drp_dbi_cs2_exp.
module dbi_slave_regfile
    import dbi_slave_pkg::*;
#(
    parameter logic [31:0] REG_BASE    = 32'h0000_0800,
    parameter int          NUM_REGS    = 64,
    parameter int          RO_LIMIT    = 16,
    parameter int          WR_PROT_IDX = 6'h2F,
    parameter int          ACK_LAT     = 2,
    parameter logic [31:0] DEVICE_ID   = 32'h1B5E_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        drp_dbi_cs,
    input  logic        drp_dbi_cs2_exp,
    input  logic [3:0]  drp_dbi_wr,
    input  logic [31:0] drp_dbi_addr,
    input  logic [31:0] drp_dbi_din,
    input  logic        drp_app_dbi_ro_wr_disable,
    output logic [31:0] drp_lbc_dbi_dout,
    output logic        drp_lbc_dbi_ack
);

    localparam int               IDX_W     = $clog2(NUM_REGS);
    localparam logic [31:0]      WIN_BYTES = 32'(4 * NUM_REGS);
    localparam logic [IDX_W-1:0] PROT_L    = IDX_W'(WR_PROT_IDX);

    dbi_state_e  state;
    logic [3:0]  cnt;
    logic [31:0] addr_q, din_q;
    logic [3:0]  wr_q;
    logic        cs2_q;

    // With ACK_LAT=1 the commit happens on the sampling edge itself, so the
    // access fields come straight from the bus while in IDLE.
    logic        idle;
    logic [31:0] acc_addr, acc_din, off;
    logic [3:0]  acc_wr;
    logic        acc_cs2;
    logic [IDX_W-1:0] idx;
    logic        in_win, is_wr, go_ack, ro_idx, wr_ok, commit, prim_prot;
    logic        prim_we, prim_re;

    assign idle     = (state == S_IDLE);
    assign acc_addr = idle ? drp_dbi_addr    : addr_q;
    assign acc_din  = idle ? drp_dbi_din     : din_q;
    assign acc_wr   = idle ? drp_dbi_wr      : wr_q;
    assign acc_cs2  = idle ? drp_dbi_cs2_exp : cs2_q;

    // Unsigned subtraction wraps addresses below REG_BASE out of the window.
    assign off    = acc_addr - REG_BASE;
    assign in_win = (off < WIN_BYTES);
    assign idx    = off[IDX_W+1:2];
    assign is_wr  = |acc_wr;

    assign go_ack = drp_dbi_cs &&
                    ((idle && ACK_LAT == 1) || (state == S_WAIT && cnt == 4'd0));

    assign ro_idx = ({{(32-IDX_W){1'b0}}, idx} < RO_LIMIT) && (idx != PROT_L);
    assign wr_ok  = !ro_idx || (prim_prot && !drp_app_dbi_ro_wr_disable);
    assign commit = go_ack && is_wr && in_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            cnt             <= '0;
            addr_q          <= '0;
            din_q           <= '0;
            wr_q            <= '0;
            cs2_q           <= 1'b0;
            drp_lbc_dbi_ack <= 1'b0;
        end else begin
            drp_lbc_dbi_ack <= go_ack;
            case (state)
                S_IDLE: if (drp_dbi_cs) begin
                    addr_q <= drp_dbi_addr;
                    din_q  <= drp_dbi_din;
                    wr_q   <= drp_dbi_wr;
                    cs2_q  <= drp_dbi_cs2_exp;
                    cnt    <= 4'(ACK_LAT - 1);
                    state  <= (ACK_LAT == 1) ? S_ACK : S_WAIT;
                end
                S_WAIT: begin
                    if (!drp_dbi_cs)      state <= S_IDLE;  // abort
                    else if (cnt == 4'd0) state <= S_ACK;
                    else                  cnt   <= cnt - 4'd1;
                end
                S_ACK:  state <= S_HOLD;
                S_HOLD: if (!drp_dbi_cs) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [31:0] prim_rdata;

`ifdef DBI_CS2_SHADOW_EN
    logic        sh_we, sh_re, sh_sel, shadow_prot_unused;
    logic [31:0] sh_rdata;

    assign prim_we = commit && !acc_cs2 && wr_ok;
    assign prim_re = go_ack && !is_wr && !acc_cs2;
    assign sh_we   = commit && acc_cs2;
    assign sh_re   = go_ack && !is_wr && acc_cs2;

    // Remembers which bank served the last read so dout holds across writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  sh_sel <= 1'b0;
        else if (go_ack && !is_wr)   sh_sel <= acc_cs2;
    end

    dbi_slave_regbank #(
        .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .RST_WORD0(32'h0), .PROT_IDX(WR_PROT_IDX)
    ) u_shadow (
        .clk(clk), .rst_n(rst_n),
        .wr_en(sh_we), .wr_be(acc_wr), .wr_idx(idx), .wr_data(acc_din),
        .rd_en(sh_re), .rd_zero(!in_win), .rd_idx(idx),
        .rd_data(sh_rdata), .prot_open(shadow_prot_unused)
    );

    assign drp_lbc_dbi_dout = sh_sel ? sh_rdata : prim_rdata;
`else
    logic cs2_unused;
    assign cs2_unused       = acc_cs2;
    assign prim_we          = commit && wr_ok;
    assign prim_re          = go_ack && !is_wr;
    assign drp_lbc_dbi_dout = prim_rdata;
`endif

    dbi_slave_regbank #(
        .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .RST_WORD0(DEVICE_ID), .PROT_IDX(WR_PROT_IDX)
    ) u_prim (
        .clk(clk), .rst_n(rst_n),
        .wr_en(prim_we), .wr_be(acc_wr), .wr_idx(idx), .wr_data(acc_din),
        .rd_en(prim_re), .rd_zero(!in_win), .rd_idx(idx),
        .rd_data(prim_rdata), .prot_open(prim_prot)
    );

endmodule
